seg_scan_driver: RTL

Downstream display stage for the count game's eight-digit seven-segment display. It takes eight 4-bit digit codes plus per-digit decimal-point, blank and blink masks from the game controller, and time-multiplexes them onto the shared `seg` bus and the active-low `dig` selects. Updates are staged and applied only at frame boundaries, so a displayed number never tears mid-frame. A dead cycle at each digit change suppresses ghosting.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_decoder.sv | 32 +++
 rtl/seg_scan_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, glyph
// patterns (gfedcba, active-high) and idle levels for the seg/dig buses.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [7:0] DIG_OFF = 8'hFF;
  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg_decoder.sv
// Hex code to seven-segment glyph (gfedcba), purely combinational.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_0;
    case (code)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned updates,
// per-digit blank/blink/dp masks and a dead cycle at every digit change.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  seg,
  output logic [7:0]  dig,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(SCAN_DIV - 2);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          pending;

  logic [31:0] st_digits, sh_digits;
  logic [7:0]  st_dp, st_blank, st_blink;
  logic [7:0]  sh_dp, sh_blank, sh_blink;

  logic [3:0] cur_code;
  logic [6:0] cur_glyph;
  logic       visible;
  logic       wrap;

  assign cur_code = sh_digits[{idx, 2'b00} +: 4];
  assign visible  = !sh_blank[idx] && !(sh_blink[idx] && blink_ph);
  assign wrap     = (idx == 3'd7) && (cnt == CNT_LAST);

  seg_decoder u_dec (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      pending    <= 1'b0;
      st_digits  <= '0;
      st_dp      <= '0;
      st_blank   <= '0;
      st_blink   <= '0;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_blink   <= '0;
      dig        <= DIG_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        st_digits <= digits;
        st_dp     <= dp_mask;
        st_blank  <= blank_mask;
        st_blink  <= blink_mask;
        pending   <= 1'b1;
      end
      if (!en) begin
        cnt        <= '0;
        idx        <= '0;
        blink_cnt  <= '0;
        blink_ph   <= 1'b0;
        dig        <= DIG_OFF;
        seg        <= SEG_OFF;
        frame_done <= 1'b0;
      end else begin
        // Look one cycle ahead so the pulse lines up with the wrap cycle itself.
        frame_done <= (idx == 3'd7) && (cnt == CNT_PRE);
        if (cnt == '0 || !visible) begin
          dig <= DIG_OFF;
          seg <= SEG_OFF;
        end else begin
          dig <= ~(8'b1 << idx);
          seg <= {sh_dp[idx], cur_glyph};
        end
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          idx <= idx + 3'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        if (wrap) begin
          // A load on the wrap cycle itself bypasses the staging registers.
          if (load || pending) begin
            sh_digits <= load ? digits     : st_digits;
            sh_dp     <= load ? dp_mask    : st_dp;
            sh_blank  <= load ? blank_mask : st_blank;
            sh_blink  <= load ? blink_mask : st_blink;
            pending   <= 1'b0;
          end
          if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end
    end
  end

endmodule
